// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  // Quotient returned for any division by zero.
  localparam logic [MDU_XLEN-1:0] DIV0_Q = '1;

  // Encoding follows the RV32M funct3 field.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on magnitudes.
// Multiply: acc = {partial_hi, multiplier_remaining}, operand = multiplicand.
// Divide:   acc = {remainder, dividend/quotient bits}, operand = divisor.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted_rem;
  logic [XLEN-1:0] diff;

  // Compute the next accumulator for the selected iteration kind.
  always_comb begin
    add_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    shifted_rem = acc[2*XLEN-1:XLEN-1];
    // Only used when shifted_rem >= operand, so the result fits in XLEN bits.
    diff        = shifted_rem[XLEN-1:0] - operand;
    if (div_mode) begin
      if (shifted_rem >= {1'b0, operand}) begin
        acc_next = {diff, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {add_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the Execute stage.
// Latches one op, iterates XLEN cycles on magnitudes, fixes signs, pulses done.
module ex_muldiv_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mem_hold,
  input  logic            kill,
  output logic            busy,
  output logic            ex_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t        state;
  mdu_op_t           op_q;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   res;

  mdu_op_t           op_in;
  logic              in_div;
  logic              in_sa;
  logic              in_sb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_by_zero;
  logic              div_ovf;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed;
  logic [XLEN-1:0]   rem_signed;
  logic [XLEN-1:0]   fix_val;

  // Decode the incoming operation: sign flags, magnitudes and fast-path cases.
  always_comb begin
    op_in       = mdu_op_t'(op);
    in_div      = op[2];
    in_sa       = a[XLEN-1] && (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU);
    in_sb       = b[XLEN-1] && (op_in == OP_MUL || op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
    mag_a       = in_sa ? -a : a;
    mag_b       = in_sb ? -b : b;
    div_by_zero = in_div && (b == '0);
    // Signed overflow: most negative value divided by -1.
    div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (op_q[2]),
    .acc_next (acc_next)
  );

  // Apply operand signs to the magnitude result and select the output word.
  always_comb begin
    prod_signed = (sa ^ sb) ? -acc : acc;
    quo_signed  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_signed  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_val     = '0;
    case (op_q)
      OP_MUL:                      fix_val = prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = quo_signed;
      default:                     fix_val = rem_signed;
    endcase
  end

  // Sequencer FSM; kill beats mem_hold, mem_hold freezes everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_MUL;
      sa      <= 1'b0;
      sb      <= 1'b0;
      operand <= '0;
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else if (!mem_hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_in;
            sa   <= in_sa;
            sb   <= in_sb;
            cnt  <= '0;
            if (div_by_zero) begin
              res   <= op[1] ? a : DIV0_Q;
              state <= DONE;
            end else if (div_ovf) begin
              res   <= op[1] ? '0 : a;
              state <= DONE;
            end else begin
              // Multiply shifts the multiplier out of the low word; divide
              // shifts the dividend out of it.
              operand <= in_div ? mag_b : mag_a;
              acc     <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
              state   <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          res   <= fix_val;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs; stall drops in DONE so EX/MEM captures the result.
  always_comb begin
    busy     = (state != IDLE);
    ex_stall = ((state == IDLE) && start && !kill) || (state == CALC) || (state == FIX);
    done     = (state == DONE);
    result   = res;
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed, randomized, hold, kill, reset.
module tb_ex_muldiv_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mem_hold;
  logic        kill;
  logic        busy;
  logic        ex_stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mem_hold (mem_hold),
    .kill     (kill),
    .busy     (busy),
    .ex_stall (ex_stall),
    .done     (done),
    .result   (result)
  );

  // Reference result straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      uy;
    logic [63:0] p;
    int          xi;
    int          yi;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'b0, y});
    xi = $signed(x);
    yi = $signed(y);
    r  = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
      3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == MIN_INT && y == 32'hFFFF_FFFF) r = x;
        else r = 32'(xi / yi);
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == MIN_INT && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(xi % yi);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Issue one op at cycle 0 and observe 55 cycles; exp_lat<0 means no done expected.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat, input int exp_ndone,
                        input int hold_at, input int hold_len, input int kill_at);
    int          first;
    int          nd;
    bit          stall_ok;
    logic [31:0] got;
    first    = -1;
    nd       = 0;
    stall_ok = 1'b1;
    got      = '0;
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    #1;
    checks++;
    if (ex_stall !== 1'b1) begin
      errors++;
      $display("FAIL %s stall0: ex_stall=%b expected 1", name, ex_stall);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) begin
          first = k;
          got   = result;
        end
        nd++;
      end
      if (ex_stall !== ((first < 0 && k <= kill_at) ? 1'b1 : 1'b0)) stall_ok = 1'b0;
      mem_hold = (k >= hold_at && k < hold_at + hold_len);
      kill     = (k == kill_at);
    end
    mem_hold = 1'b0;
    kill     = 1'b0;
    $display("%s op=%0d a=%h b=%h result=%h first_done=%0d done_cycles=%0d", name, o, x, y, got, first, nd);
    checks++;
    if (first != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, first, exp_lat);
    end
    checks++;
    if (nd != exp_ndone) begin
      errors++;
      $display("FAIL %s done_cycles: got %0d expected %0d", name, nd, exp_ndone);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL %s stall_profile: ex_stall deviated from expected window", name);
    end
    if (exp_ndone > 0) begin
      checks++;
      if (got !== exp_res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, got, exp_res);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; mem_hold = 1'b0; kill = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ex_stall, done, result} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b stall=%b done=%b result=%h expected all 0", busy, ex_stall, done, result);
    end
    $display("reset busy=%b stall=%b done=%b result=%h", busy, ex_stall, done, result);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1, 999, 0, 999);
    run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1, 999, 0, 999);
    run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1, 999, 0, 999);
    run_op("div_m20_6",  3'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34, 1, 999, 0, 999);
    run_op("rem_m20_6",  3'd6, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34, 1, 999, 0, 999);
    run_op("divu_20_6",  3'd5, 32'd20, 32'd6, 32'd3, 34, 1, 999, 0, 999);
    run_op("divu_by0",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 999, 0, 999);
    run_op("remu_by0",   3'd7, 32'd5, 32'd0, 32'd5, 1, 1, 999, 0, 999);
    run_op("div_ovf",    3'd4, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 1, 1, 999, 0, 999);
    run_op("rem_ovf",    3'd6, MIN_INT, 32'hFFFF_FFFF, 32'd0, 1, 1, 999, 0, 999);
    run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1, 999, 0, 999);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = MIN_INT; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 100)); y = 32'($urandom_range(1, 12)); end
        3: y = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("random", o, x, y, model(o, x, y), model_lat(o, x, y), 1, 999, 0, 999);
    end
  endtask

  task automatic test_hold();
    logic [31:0] x;
    logic [31:0] y;
    x = $urandom;
    y = $urandom;
    run_op("hold_calc", 3'd0, x, y, model(3'd0, x, y), 39, 1, 10, 5, 999);
    x = $urandom;
    y = 32'($urandom_range(1, 1000));
    run_op("hold_done", 3'd6, x, y, model(3'd6, x, y), 34, 4, 34, 3, 999);
  endtask

  task automatic test_kill();
    logic [31:0] x;
    logic [31:0] y;
    run_op("kill_calc", 3'd1, $urandom, $urandom, 32'd0, -1, 0, 999, 0, 10);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle: busy=%b expected 0", busy);
    end
    x = $urandom;
    y = 32'($urandom_range(1, 50));
    run_op("after_kill", 3'd5, x, y, model(3'd5, x, y), 34, 1, 999, 0, 999);
  endtask

  task automatic test_async_reset();
    int nd;
    nd = 0;
    @(negedge clk);
    op = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, ex_stall, done, result} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b stall=%b done=%b result=%h expected all 0", busy, ex_stall, done, result);
    end
    $display("async_reset busy=%b stall=%b done=%b result=%h", busy, ex_stall, done, result);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL async_reset_no_done: got %0d done cycles expected 0", nd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_kill();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
